// File: rtl/seq_booth_mult_param.sv
// ---------------------------------------------------------------------------
// seq_booth_mult_param
//   Sequential radix-4 (modified Booth) multiplier. Retires two multiplier
//   bits per clock, with a per-operation signed/unsigned mode.
//
// Parameters
//   WIDTH      operand width (even, >= 4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a_in       multiplicand (sampled with start)
//   b_in       multiplier   (sampled with start)
//   busy       high while an operation is in progress
//   p_out      2*WIDTH-bit product, held between done pulses
//   done       one-cycle pulse when p_out has just been updated
// ---------------------------------------------------------------------------
module seq_booth_mult_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   p_out,
  output logic                 done
);

  localparam int ITER = WIDTH / 2 + 1;   // Booth iterations per operation
  localparam int EW   = WIDTH + 2;       // extended operand width
  localparam int HW   = WIDTH + 4;       // upper accumulator slice, room for +/-2A
  localparam int CW   = $clog2(ITER);

  generate
    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("seq_booth_mult_param: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [EW-1:0]        a_q, a_d;
  logic [HW-1:0]        hi_q, hi_d;     // upper accumulator slice
  logic [EW-1:0]        lo_q, lo_d;     // multiplier, shifted out as product bits shift in
  logic                 bm1_q, bm1_d;   // b[2i-1] for the current triplet
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 done_q, done_d;

  logic [2:0]           trip;
  logic [HW-1:0]        a_wide;
  logic [HW-1:0]        pp;
  logic [HW-1:0]        sum;

  // Extension bits: zero in unsigned mode, sign bit in signed mode.
  logic                 a_ext_bit, b_ext_bit;

  assign a_ext_bit = is_signed & a_in[WIDTH-1];
  assign b_ext_bit = is_signed & b_in[WIDTH-1];

  assign trip   = {lo_q[1:0], bm1_q};
  assign a_wide = {{(HW-EW){a_q[EW-1]}}, a_q};

  // Booth partial-product select
  always_comb begin
    pp = '0;
    case (trip)
      3'b001, 3'b010: pp = a_wide;
      3'b011:         pp = a_wide << 1;
      3'b100:         pp = -(a_wide << 1);
      3'b101, 3'b110: pp = -a_wide;
      default:        pp = '0;
    endcase
  end

  assign sum = hi_q + pp;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    bm1_d   = bm1_q;
    p_d     = p_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {{2{a_ext_bit}}, a_in};
          lo_d    = {{2{b_ext_bit}}, b_in};
          hi_d    = '0;
          bm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Add the partial product, then arithmetic-shift {hi,lo,bm1} right by 2.
        hi_d  = {{2{sum[HW-1]}}, sum[HW-1:2]};
        lo_d  = {sum[1:0], lo_q[EW-1:2]};
        bm1_d = lo_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // After ITER shifts lo holds the low WIDTH+2 product bits.
        p_d     = {hi_q[WIDTH-3:0], lo_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      bm1_q   <= 1'b0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      bm1_q   <= bm1_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign p_out = p_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_booth_mult_param.sv
// ---------------------------------------------------------------------------
// tb_seq_booth_mult_param
//   Directed bench for a WIDTH=16 and a WIDTH=8 instance. Stimulus pushes
//   hand-computed products into per-instance queues; monitors pop and compare
//   whenever done is seen.
// ---------------------------------------------------------------------------
module tb_seq_booth_mult_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16_n, start16, sgn16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic        rst8_n, start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  seq_booth_mult_param #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst16_n), .start(start16), .is_signed(sgn16),
    .a_in(a16), .b_in(b16), .busy(busy16), .p_out(p16), .done(done16)
  );

  seq_booth_mult_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .is_signed(sgn8),
    .a_in(a8), .b_in(b8), .busy(busy8), .p_out(p8), .done(done8)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] q16[$];
  logic [15:0] q8[$];
  logic [31:0] prev16 = 32'h0;
  logic [15:0] prev8  = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        checks++; failures++;
        $display("FAIL w16_unexpected_done actual=%h required=no_done", p16);
      end else begin
        $display("txn w16 p_out=%h expected=%h", p16, q16[0]);
        chk("w16_product", p16, q16.pop_front());
      end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL w8_unexpected_done actual=%h required=no_done", p8);
      end else begin
        $display("txn w8 p_out=%h expected=%h", p8, q8[0]);
        chk("w8_product", {16'h0, p8}, {16'h0, q8.pop_front()});
      end
    end
  end

  task automatic set_in(input bit w8, input logic st, input logic s,
                        input logic [15:0] a, input logic [15:0] b);
    if (w8) begin
      start8 = st; sgn8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = st; sgn16 = s; a16 = a; b16 = b;
    end
  endtask

  function automatic logic [31:0] get_busy(input bit w8);
    return w8 ? {31'h0, busy8} : {31'h0, busy16};
  endfunction

  function automatic logic [31:0] get_done(input bit w8);
    return w8 ? {31'h0, done8} : {31'h0, done16};
  endfunction

  function automatic logic [31:0] get_p(input bit w8);
    return w8 ? {16'h0, p8} : p16;
  endfunction

  // Wait (bounded) for done; returns edges elapsed and busy-high samples.
  task automatic wait_done(input bit w8, output int k, output int bc);
    k = 0; bc = 0;
    while (1) begin
      if (get_busy(w8) == 32'd1) bc++;
      if (get_done(w8) == 32'd1 || k >= 40) break;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run(input bit w8, input logic s, input logic [15:0] a,
                     input logic [15:0] b, input logic [31:0] exp, input string nm);
    int iter;
    int k;
    int bc;
    logic [31:0] prv;
    iter = w8 ? 5 : 9;
    prv  = w8 ? {16'h0, prev8} : prev16;
    set_in(w8, 1'b1, s, a, b);
    if (w8) q8.push_back(exp[15:0]); else q16.push_back(exp);
    @(posedge clk); #1;                         // E0: start accepted
    set_in(w8, 1'b0, ~s, 16'hA5A5, 16'h5A5A);   // later input changes must be ignored
    chk({nm, "_busy_after_start"}, get_busy(w8), 32'd1);
    chk({nm, "_p_held"}, get_p(w8), prv);
    wait_done(w8, k, bc);
    chk({nm, "_done_latency"}, k, iter + 1);
    chk({nm, "_busy_cycles"}, bc, iter + 1);
    @(posedge clk); #1;
    chk({nm, "_done_falls"}, get_done(w8), 32'd0);
    if (w8) prev8 = exp[15:0]; else prev16 = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int bc;
    rst16_n = 1'b0; rst8_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    #12;
    chk("reset_busy16", {31'h0, busy16}, 32'd0);
    chk("reset_done16", {31'h0, done16}, 32'd0);
    chk("reset_p16",    p16,             32'd0);
    chk("reset_busy8",  {31'h0, busy8},  32'd0);
    chk("reset_done8",  {31'h0, done8},  32'd0);
    chk("reset_p8",     {16'h0, p8},     32'd0);
    @(negedge clk);
    rst16_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk); #1;

    // Directed WIDTH=16 vectors
    run(1'b0, 1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, "s_m3x7");
    run(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u_ffff2");
    run(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, "s_m1x_m1");
    run(1'b0, 1'b1, 16'h8000, 16'h8000, 32'h40000000, "s_minxmin");
    run(1'b0, 1'b0, 16'h8000, 16'h0002, 32'h00010000, "u_8000x2");
    run(1'b0, 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, "s_maxxmin");
    run(1'b0, 1'b0, 16'hFFFF, 16'h0000, 32'h00000000, "u_zero");

    // Hold-off: p_out keeps its value while idle
    repeat (5) @(posedge clk);
    #1;
    chk("w16_p_hold_idle", p16, prev16);

    // start held high: back-to-back operations, operands changed mid-CALC
    set_in(1'b0, 1'b1, 1'b1, 16'd5, 16'd6);
    q16.push_back(32'd30);
    q16.push_back(32'h00000001);
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    wait_done(1'b0, k, bc);
    chk("b2b_first_latency", k, 10);
    chk("b2b_first_busy",    bc, 10);
    @(posedge clk); #1;
    chk("b2b_second_accepted", {31'h0, busy16}, 32'd1);
    chk("b2b_done_low",        {31'h0, done16}, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 16'h0002, 16'h0002);
    wait_done(1'b0, k, bc);
    chk("b2b_second_latency", k, 10);
    prev16 = 32'h00000001;
    @(posedge clk); #1;

    // Asynchronous reset during CALC iteration 4: no done must follow
    set_in(1'b0, 1'b1, 1'b0, 16'd3, 16'd4);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (4) @(posedge clk);
    #3;
    rst16_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy16}, 32'd0);
    chk("arst_done", {31'h0, done16}, 32'd0);
    chk("arst_p",    p16,             32'd0);
    @(negedge clk);
    rst16_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("arst_no_done", {31'h0, done16}, 32'd0);
    prev16 = 32'h0;
    run(1'b0, 1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, "after_rst");

    // WIDTH=8 instance
    run(1'b1, 1'b1, 16'h0080, 16'h007F, 32'h0000C080, "w8_s_m128x127");
    run(1'b1, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, "w8_u_ff2");
    run(1'b1, 1'b1, 16'h0080, 16'h0080, 32'h00004000, "w8_s_minxmin");

    repeat (3) @(posedge clk);
    #1;
    chk("w16_queue_drained", q16.size(), 32'd0);
    chk("w8_queue_drained",  q8.size(),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
